// File: rtl/paddle_motion_ctrl.sv
// Pong paddle motion: stretches scanned key flags, rate-limits and
// accelerates paddle movement, clamps both paddles to the playfield.
module paddle_motion_ctrl #(
  parameter int Y_W         = 8,
  parameter int Y_MAX       = 104,
  parameter int Y_INIT      = 52,
  parameter int HOLD_CYCLES = 4,
  parameter int MOVE_DIV    = 4,
  parameter int STEP        = 1,
  parameter int FAST_STEP   = 3,
  parameter int ACCEL_AFTER = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           recenter,
  input  logic           up1,
  input  logic           down1,
  input  logic           up2,
  input  logic           down2,
  output logic [Y_W-1:0] p1_y,
  output logic [Y_W-1:0] p2_y,
  output logic           p1_moving,
  output logic           p2_moving
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int DW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam logic [HW-1:0]  HOLD_L = HW'(HOLD_CYCLES);
  localparam logic [DW-1:0]  DIV_L  = DW'(MOVE_DIV - 1);
  localparam logic [Y_W:0]   YMAX_X = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W-1:0] YINI_L = Y_W'(Y_INIT);
  localparam logic [Y_W:0]   STEP_X = (Y_W+1)'(STEP);
  localparam logic [Y_W:0]   FAST_X = (Y_W+1)'(FAST_STEP);
  localparam logic [2:0]     ACC_L  = 3'(ACCEL_AFTER);

  typedef enum logic [1:0] {
    DIR_IDLE,
    DIR_UP,
    DIR_DN
  } dir_e;

  logic [HW-1:0]  hold_q [4];
  logic [HW-1:0]  hold_d [4];
  logic [DW-1:0]  div_q, div_d;
  logic [Y_W-1:0] y_q [2];
  logic [Y_W-1:0] y_d [2];
  logic [2:0]     streak_q [2];
  logic [2:0]     streak_d [2];
  dir_e           last_q [2];
  dir_e           last_d [2];
  logic           mov_q [2];
  logic           mov_d [2];

  logic [3:0]     flag;
  logic           tick;
  dir_e           dir_w [2];
  logic [Y_W:0]   step_w [2];

  function automatic logic [Y_W-1:0] y_next(
    input logic [Y_W-1:0] y,
    input dir_e            d,
    input logic [Y_W:0]    st
  );
    logic [Y_W:0] yx;
    logic [Y_W:0] sum;
    yx     = {1'b0, y};
    sum    = yx + st;
    y_next = y;
    unique case (1'b1)
      d == DIR_UP: y_next = (yx < st) ? '0 : Y_W'(yx - st);
      d == DIR_DN: y_next = (sum > YMAX_X) ? YMAX_X[Y_W-1:0]
                                           : sum[Y_W-1:0];
      default:     y_next = y;
    endcase
  endfunction

  always_comb begin
    flag = {down2, up2, down1, up1};
    for (int i = 0; i < 4; i++) begin
      hold_d[i] = flag[i] ? HOLD_L
                : (hold_q[i] != '0) ? hold_q[i] - 1'b1 : '0;
    end

    tick  = en && (div_q == DIV_L);
    div_d = '0;
    if (en && !recenter && !tick) div_d = div_q + 1'b1;

    for (int p = 0; p < 2; p++) begin
      dir_w[p]    = DIR_IDLE;
      step_w[p]   = STEP_X;
      y_d[p]      = y_q[p];
      streak_d[p] = streak_q[p];
      last_d[p]   = last_q[p];
      mov_d[p]    = mov_q[p];

      unique case (1'b1)
        (hold_q[2*p] != '0) && (hold_q[2*p+1] == '0): dir_w[p] = DIR_UP;
        (hold_q[2*p] == '0) && (hold_q[2*p+1] != '0): dir_w[p] = DIR_DN;
        default:                                      dir_w[p] = DIR_IDLE;
      endcase

      if (recenter) begin
        y_d[p]      = YINI_L;
        streak_d[p] = '0;
        last_d[p]   = DIR_IDLE;
        mov_d[p]    = 1'b0;
      end else if (!en) begin
        streak_d[p] = '0;
        last_d[p]   = DIR_IDLE;
        mov_d[p]    = 1'b0;
      end else if (tick) begin
        // streak counts repeats of the previous tick's direction
        if (dir_w[p] != DIR_IDLE && dir_w[p] == last_q[p])
          streak_d[p] = (streak_q[p] == 3'd7) ? 3'd7 : streak_q[p] + 3'd1;
        else
          streak_d[p] = '0;
        last_d[p]   = dir_w[p];
        step_w[p]   = (streak_d[p] >= ACC_L) ? FAST_X : STEP_X;
        y_d[p]      = y_next(y_q[p], dir_w[p], step_w[p]);
        mov_d[p]    = (y_d[p] != y_q[p]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) hold_q[i] <= '0;
      div_q <= '0;
      for (int p = 0; p < 2; p++) begin
        y_q[p]      <= YINI_L;
        streak_q[p] <= '0;
        last_q[p]   <= DIR_IDLE;
        mov_q[p]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) hold_q[i] <= hold_d[i];
      div_q <= div_d;
      for (int p = 0; p < 2; p++) begin
        y_q[p]      <= y_d[p];
        streak_q[p] <= streak_d[p];
        last_q[p]   <= last_d[p];
        mov_q[p]    <= mov_d[p];
      end
    end
  end

  assign p1_y      = y_q[0];
  assign p2_y      = y_q[1];
  assign p1_moving = mov_q[0];
  assign p2_moving = mov_q[1];

endmodule
